// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: freezes every core, programs CORE_ID/DID/NPC,
// then unfreezes all cores over a valid/ready config-write channel.
module bp_cfg_loader #(
  parameter int cc_x_dim_p    = 2,
  parameter int cc_y_dim_p    = 1,
  parameter int vaddr_width_p = 39,
  parameter int did_width_p   = 3,
  localparam int num_core_lp  = cc_x_dim_p * cc_y_dim_p,
  localparam int core_w_lp    = (num_core_lp > 1) ? $clog2(num_core_lp) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [vaddr_width_p-1:0] boot_pc_i,
  input  logic [did_width_p-1:0]   did_i,
  output logic                     cfg_v_o,
  input  logic                     cfg_ready_i,
  output logic [core_w_lp-1:0]     cfg_core_o,
  output logic [1:0]               cfg_addr_o,
  output logic [63:0]              cfg_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_UNFREEZE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_FREEZE  = 2'd0,
    REG_CORE_ID = 2'd1,
    REG_DID     = 2'd2,
    REG_NPC     = 2'd3
  } cfg_reg_e;

  localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_lp - 1);

  state_e                   state_q, state_d;
  logic [core_w_lp-1:0]     core_q, core_d;
  cfg_reg_e                 reg_q, reg_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [did_width_p-1:0]   did_q, did_d;
  logic                     hs;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      core_q  <= '0;
      reg_q   <= REG_FREEZE;
      pc_q    <= '0;
      did_q   <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      reg_q   <= reg_d;
      pc_q    <= pc_d;
      did_q   <= did_d;
    end
  end

  assign hs = cfg_v_o && cfg_ready_i;

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    reg_d   = reg_q;
    pc_d    = pc_q;
    did_d   = did_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_CFG;
          core_d  = '0;
          reg_d   = REG_FREEZE;
          pc_d    = boot_pc_i;
          did_d   = did_i;
        end
      end
      ST_CFG: begin
        if (hs) begin
          if (reg_q == REG_NPC) begin
            reg_d = REG_FREEZE;
            if (core_q == last_core_lp) begin
              core_d  = '0;
              state_d = ST_UNFREEZE;
            end else begin
              core_d = core_q + core_w_lp'(1);
            end
          end else begin
            reg_d = cfg_reg_e'(reg_q + 2'd1);
          end
        end
      end
      ST_UNFREEZE: begin
        // The core counter parks on the last core rather than wrapping.
        if (hs) begin
          if (core_q == last_core_lp) state_d = ST_DONE;
          else                        core_d  = core_q + core_w_lp'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = 2'd0;
    cfg_data_o = 64'd0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      ST_CFG: begin
        cfg_v_o    = 1'b1;
        busy_o     = 1'b1;
        cfg_core_o = core_q;
        cfg_addr_o = reg_q;
        unique case (reg_q)
          REG_FREEZE:  cfg_data_o = 64'd1;
          REG_CORE_ID: cfg_data_o = 64'(core_q);
          REG_DID:     cfg_data_o = 64'(did_q);
          REG_NPC:     cfg_data_o = 64'(pc_q);
          default:     cfg_data_o = 64'd0;
        endcase
      end
      ST_UNFREEZE: begin
        cfg_v_o    = 1'b1;
        busy_o     = 1'b1;
        cfg_core_o = core_q;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench for bp_cfg_loader: a 2-core instance for the main scenarios and
// a 1-core instance for the degenerate configuration.
module tb_bp_cfg_loader;

  typedef struct {
    int          core;
    int          addr;
    logic [63:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [38:0] boot_pc;
  logic [2:0]  did;
  logic        ready;
  logic        cfg_v;
  logic [0:0]  cfg_core;
  logic [1:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        busy;
  logic        done;

  logic        start_1;
  logic        cfg_v_1;
  logic [0:0]  cfg_core_1;
  logic [1:0]  cfg_addr_1;
  logic [63:0] cfg_data_1;
  logic        busy_1;
  logic        done_1;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];

  bp_cfg_loader u_dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .boot_pc_i  (boot_pc),
    .did_i      (did),
    .cfg_v_o    (cfg_v),
    .cfg_ready_i(ready),
    .cfg_core_o (cfg_core),
    .cfg_addr_o (cfg_addr),
    .cfg_data_o (cfg_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  bp_cfg_loader #(.cc_x_dim_p(1), .cc_y_dim_p(1)) u_one (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start_1),
    .boot_pc_i  (boot_pc),
    .did_i      (did),
    .cfg_v_o    (cfg_v_1),
    .cfg_ready_i(1'b1),
    .cfg_core_o (cfg_core_1),
    .cfg_addr_o (cfg_addr_1),
    .cfg_data_o (cfg_data_1),
    .busy_o     (busy_1),
    .done_o     (done_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [38:0] pc, input logic [2:0] d, input int ncore);
    for (int k = 0; k < ncore; k++) begin
      exp_q.push_back('{k, 0, 64'd1});
      exp_q.push_back('{k, 1, 64'(k)});
      exp_q.push_back('{k, 2, 64'(d)});
      exp_q.push_back('{k, 3, 64'(pc)});
    end
    for (int k = 0; k < ncore; k++) exp_q.push_back('{k, 0, 64'd0});
  endtask

  task automatic do_start(input logic [38:0] pc, input logic [2:0] d);
    start   = 1'b1;
    boot_pc = pc;
    did     = d;
    tick();
    start = 1'b0;
  endtask

  task automatic check_cycles(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: cycles got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_quiet(input string name, input logic want_done);
    n_cmp++;
    if (cfg_v !== 1'b0 || busy !== 1'b0 || done !== want_done ||
        cfg_core !== '0 || cfg_addr !== 2'd0 || cfg_data !== 64'd0) begin
      n_bad++;
      $display("FAIL %s: v=%b busy=%b done=%b core=%0d addr=%0d data=%h want v=0 busy=0 done=%b core=0 addr=0 data=0",
               name, cfg_v, busy, done, cfg_core, cfg_addr, cfg_data, want_done);
    end
  endtask

  // Drains the scoreboard against the 2-core DUT; optional stall, mid-run start
  // pulse, or reset abort at given write indices.
  task automatic run_seq(input string name, input int stall_idx, input int stall_len,
                         input bit mid_start, input int abort_idx, output int cycles);
    int  idx = 0;
    int  stalled = 0;
    bit  mid_done = 0;
    wr_t e;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      e = exp_q[0];
      if (idx == abort_idx) begin
        reset_n = 1'b0;
        #1;
        check_quiet({name, "_async_reset"}, 1'b0);
        exp_q.delete();
        return;
      end
      n_cmp++;
      if (cfg_v !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || cfg_core !== e.core ||
          cfg_addr !== e.addr || cfg_data !== e.data) begin
        n_bad++;
        $display("FAIL %s[%0d]: v=%b busy=%b done=%b core=%0d addr=%0d data=%h want v=1 busy=1 done=0 core=%0d addr=%0d data=%h",
                 name, idx, cfg_v, busy, done, cfg_core, cfg_addr, cfg_data, e.core, e.addr, e.data);
      end
      if (idx == stall_idx && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else begin
        ready = 1'b1;
      end
      start = 1'b0;
      if (mid_start && idx == 2 && !mid_done) begin
        start    = 1'b1;
        boot_pc  = 39'h12_3456_7890;
        did      = 3'd7;
        mid_done = 1;
      end
      tick();
      cycles++;
      if (ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d writes outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
    check_quiet({name, "_done"}, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    check_quiet("reset_held", 1'b0);
    n_cmp++;
    if (cfg_v_1 !== 1'b0 || busy_1 !== 1'b0 || done_1 !== 1'b0 || cfg_core_1 !== 1'b0 ||
        cfg_addr_1 !== 2'd0 || cfg_data_1 !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_one: v=%b busy=%b done=%b want all 0", cfg_v_1, busy_1, done_1);
    end
    reset_n = 1'b1;
    tick();
    check_quiet("reset_released", 1'b0);
  endtask

  task automatic test_basic();
    int cyc;
    push_seq(39'h80000000, 3'd5, 2);
    do_start(39'h80000000, 3'd5);
    run_seq("basic", -1, 0, 0, -1, cyc);
    check_cycles("basic_latency", cyc, 10);
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("done_hold", 1'b1);
    end
  endtask

  task automatic test_restart_did();
    int cyc;
    push_seq(39'h80000000, 3'd2, 2);
    do_start(39'h80000000, 3'd2);
    run_seq("restart_did2", -1, 0, 0, -1, cyc);
    check_cycles("restart_latency", cyc, 10);
  endtask

  task automatic test_stall();
    int cyc;
    push_seq(39'h0000_1000, 3'd5, 2);
    do_start(39'h0000_1000, 3'd5);
    run_seq("stall_did", 2, 3, 0, -1, cyc);
    check_cycles("stall_latency", cyc, 13);
  endtask

  task automatic test_mid_start();
    int cyc;
    push_seq(39'h0000_2000, 3'd1, 2);
    do_start(39'h0000_2000, 3'd1);
    run_seq("mid_start", -1, 0, 1, -1, cyc);
    check_cycles("mid_start_latency", cyc, 10);
  endtask

  task automatic test_reset_mid();
    int cyc;
    push_seq(39'h0000_3000, 3'd3, 2);
    do_start(39'h0000_3000, 3'd3);
    run_seq("abort", -1, 0, 0, 9, cyc);
    tick();
    check_quiet("abort_held", 1'b0);
    reset_n = 1'b1;
    tick();
    check_quiet("abort_released", 1'b0);
    push_seq(39'h0000_4000, 3'd6, 2);
    do_start(39'h0000_4000, 3'd6);
    run_seq("after_abort", -1, 0, 0, -1, cyc);
    check_cycles("after_abort_latency", cyc, 10);
  endtask

  task automatic test_single_core();
    int  cyc = 0;
    wr_t e;
    push_seq(39'h0000_5000, 3'd4, 1);
    start_1 = 1'b1;
    boot_pc = 39'h0000_5000;
    did     = 3'd4;
    tick();
    start_1 = 1'b0;
    while (exp_q.size() > 0 && cyc < 50) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (cfg_v_1 !== 1'b1 || busy_1 !== 1'b1 || cfg_core_1 !== 1'b0 ||
          cfg_addr_1 !== e.addr || cfg_data_1 !== e.data) begin
        n_bad++;
        $display("FAIL single_core: v=%b core=%0d addr=%0d data=%h want v=1 core=0 addr=%0d data=%h",
                 cfg_v_1, cfg_core_1, cfg_addr_1, cfg_data_1, e.addr, e.data);
      end
      tick();
      cyc++;
    end
    check_cycles("single_core_latency", cyc, 5);
    n_cmp++;
    if (done_1 !== 1'b1 || cfg_v_1 !== 1'b0 || busy_1 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_core_done: done=%b v=%b busy=%b want done=1 v=0 busy=0", done_1, cfg_v_1, busy_1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    start_1 = 1'b0;
    boot_pc = '0;
    did     = '0;
    ready   = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_done_hold();
    test_restart_did();
    test_stall();
    test_mid_start();
    test_reset_mid();
    test_single_core();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
